// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of an index able to address n items (n >= 2).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_add_row.sv
// One W-bit adder/subtractor row; sub selects acc - row instead of acc + row.
module mult_add_row #(
   parameter int W = 12
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] row,
   input  logic         sub,
   output logic [W-1:0] sum
);

   assign sum = sub ? (acc - row) : (acc + row);

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative A_W x B_W multiplier, one partial-product row per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN for two's-complement operands and a signed product.
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int A_W = 8,
   parameter int B_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W+B_W-1:0] product
);

   localparam int P_W = A_W + B_W;
   localparam int C_W = clog2(B_W);
   localparam logic [C_W-1:0] LAST = C_W'(B_W - 1);

   state_t           state, state_nxt;
   logic             rdy_en;
   logic [A_W-1:0]   a_reg;
   logic [B_W-1:0]   b_reg;
   logic [C_W-1:0]   count;
   logic [P_W-1:0]   acc;
   logic [P_W-1:0]   row;
   logic [P_W-1:0]   sum;
   logic             sub;
   logic             accept;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rdy_en;
            if (in_valid && rdy_en) state_nxt = RUN;
         end
         RUN: begin
            if (count == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

`ifdef MULT_SIGNED_EN
   // MSB of b carries weight -2^(B_W-1), so its row is subtracted.
   assign row = {{B_W{a_reg[A_W-1]}}, a_reg} << count;
   assign sub = (count == LAST);
`else
   assign row = {{B_W{1'b0}}, a_reg} << count;
   assign sub = 1'b0;
`endif

   mult_add_row #(.W(P_W)) u_add_row (
      .acc (acc),
      .row (row),
      .sub (sub),
      .sum (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // rdy_en holds in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en <= 1'b0;
         a_reg  <= '0;
         b_reg  <= '0;
         count  <= '0;
         acc    <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            count <= '0;
         end else if (state == RUN) begin
            if (b_reg[count]) acc <= sum;
            count <= count + C_W'(1);
         end
      end
   end

   assign product = acc;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and reference-model checks for seq_shift_add_multiplier at A_W=8, B_W=4.
module tb_seq_shift_add_multiplier;

   localparam int A_W = 8;
   localparam int B_W = 4;
   localparam int P_W = A_W + B_W;
`ifdef MULT_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic           out_valid;
   logic           out_ready;
   logic [P_W-1:0] product;

   int n_cmp;
   int n_err;
   int lat;
   int cyc;

   seq_shift_add_multiplier #(.A_W(A_W), .B_W(B_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
      logic signed [P_W-1:0] sx, sy;
      if (SGN) begin
         sx = {{B_W{x[A_W-1]}}, x};
         sy = {{A_W{y[B_W-1]}}, y};
      end else begin
         sx = {{B_W{1'b0}}, x};
         sy = {{A_W{1'b0}}, y};
      end
      return P_W'(sx * sy);
   endfunction

   // Called #1 after an edge; returns #1 after the accept edge with in_valid dropped.
   task automatic send(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb_);
      int k;
      in_valid = 1'b1;
      a = ta;
      b = tb_;
      k = 0;
      while (!in_ready && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 40) chk("accept_timeout", 32'(k), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int l);
      l = 0;
      while (!out_valid && l < 40) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic op(input string tag, input logic [A_W-1:0] ta, input logic [B_W-1:0] tb_,
                     input logic [P_W-1:0] exp);
      send(ta, tb_);
      wait_out(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(B_W));
      chk({tag, "_prod"}, 32'(product), 32'(exp));
      @(posedge clk); #1;
      chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int c0;
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rel_in_ready_high", 32'(in_ready), 32'd1);

      op("ff_f", 8'hFF, 4'hF, SGN ? 12'h001 : 12'hEF1);

      // Hold the result with out_ready low for 10 cycles
      out_ready = 1'b0;
      send(8'hA5, 4'h9);
      wait_out(lat);
      chk("a5_9_lat", 32'(lat), 32'(B_W));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("a5_9_hold_vld", 32'(out_valid), 32'd1);
         chk("a5_9_hold_prod", 32'(product), SGN ? 32'h27D : 32'h5CD);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("a5_9_vld_drop", 32'(out_valid), 32'd0);
      chk("a5_9_idle_ready", 32'(in_ready), 32'd1);

      op("00_0", 8'h00, 4'h0, 12'h000);
      op("37_0", 8'h37, 4'h0, 12'h000);
      op("80_7", 8'h80, 4'h7, SGN ? 12'hC80 : 12'h380);
      op("80_8", 8'h80, 4'h8, 12'h400);

      // Operands offered while busy are ignored until IDLE
      send(8'h21, 4'h6);
      in_valid = 1'b1;
      a = 8'h12;
      b = 4'h3;
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      wait_out(lat);
      chk("busy_lat", 32'(lat), 32'(B_W));
      chk("busy_in_ready_done", 32'(in_ready), 32'd0);
      chk("busy_first_prod", 32'(product), 32'h0C6);
      @(posedge clk); #1;
      chk("busy_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat);
      chk("busy_second_lat", 32'(lat), 32'(B_W));
      chk("busy_second_prod", 32'(product), 32'h036);
      @(posedge clk); #1;

      // Reset during RUN with count=2
      send(8'h55, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op("03_5", 8'h03, 4'h5, 12'h00F);

      // Back-to-back random stream, out_ready held high
      c0 = cyc;
      for (int i = 0; i < 256; i++) begin
         ra = A_W'($urandom);
         rb = B_W'($urandom);
         send(ra, rb);
         wait_out(lat);
         if (lat != B_W) chk("rnd_lat", 32'(lat), 32'(B_W));
         chk("rnd_prod", 32'(product), 32'(ref_mul(ra, rb)));
         @(posedge clk); #1;
      end
      chk("rnd_throughput", 32'(cyc - c0), 32'(256 * (B_W + 2)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
